// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial frame transmitter.
// Frame on sout: start bit (0), W data bits LSB first, optional parity bit,
// stop bit (1). Every bit is held for CPB clocks; the line idles high.
//
// Parameters:
//   W    data word width (>=1)
//   CPB  clocks per bit (>=1)
//   PAR  parity mode: 0 none, 1 even, 2 odd; any other value means none
//
// Ports:
//   c      clock, all state changes on its rising edge
//   r      synchronous active-high reset, overrides every other input
//   din    word to transmit, sampled only on the accepting edge
//   load   transmit request; a transfer happens on an edge with ready & load
//   ready  high only while idle
//   sout   registered serial line
//   busy   high from the edge after accept until the return to idle
//   done   one-cycle pulse in the first idle cycle after a stop bit
module ser_tx #(
  parameter int W   = 8,
  parameter int CPB = 1,
  parameter int PAR = 0
) (
  input  logic         c,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] PER_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam bit PAR_EN  = (PAR == 1) || (PAR == 2);
  localparam bit PAR_ODD = (PAR == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]  bit_q,   bit_d;
  logic [CW-1:0]  per_q,   per_d;
  logic           par_q,   par_d;
  logic           sout_q,  sout_d;
  logic           done_q,  done_d;

  logic           per_end;
  logic [W-1:0]   shreg_shift;

  assign per_end     = (per_q == PER_LAST);
  assign shreg_shift = shreg_q >> 1;

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      per_q   <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // sout_d always holds the level of the bit the next state will present,
  // so sout stays a plain register with no path from load/din.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    per_d   = per_q;
    par_d   = par_q;
    sout_d  = sout_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sout_d = 1'b1;
        if (load) begin
          shreg_d = din;
          par_d   = PAR_ODD ? ~^din : ^din;
          bit_d   = '0;
          per_d   = '0;
          sout_d  = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (per_end) begin
          per_d   = '0;
          sout_d  = shreg_q[0];
          state_d = S_DATA;
        end else begin
          per_d = per_q + CW'(1);
        end
      end

      S_DATA: begin
        if (per_end) begin
          per_d   = '0;
          shreg_d = shreg_shift;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            if (PAR_EN) begin
              sout_d  = par_q;
              state_d = S_PARITY;
            end else begin
              sout_d  = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            sout_d = shreg_shift[0];
          end
        end else begin
          per_d = per_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (per_end) begin
          per_d   = '0;
          sout_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          per_d = per_q + CW'(1);
        end
      end

      S_STOP: begin
        if (per_end) begin
          per_d   = '0;
          sout_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          per_d = per_q + CW'(1);
        end
      end

      default: begin
        sout_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign sout  = sout_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx. Four instances cover PAR=0/1/2 at CPB=1 and PAR=0 at
// CPB=4; sel picks the instance that receives load and is observed.
// Expected per-cycle outputs {sout,busy,ready,done} are queued with the
// cycle number at which they must appear; the monitor compares on negedge.
module tb_ser_tx;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic [7:0] din = 8'h00;
  logic       load = 1'b0;
  int         sel = 0;
  int         cyc = 0;

  logic       load_v  [4];
  logic       ready_v [4];
  logic       sout_v  [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic [3:0] obs;

  typedef struct {
    int         cy;
    logic [3:0] exp;
    string      tag;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < 4; k++) load_v[k] = load && (sel == k);
    obs = {sout_v[sel], busy_v[sel], ready_v[sel], done_v[sel]};
  end

  ser_tx #(.W(8), .CPB(1), .PAR(0)) u_p0 (
    .c(clk), .r(r), .din(din), .load(load_v[0]),
    .ready(ready_v[0]), .sout(sout_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  ser_tx #(.W(8), .CPB(1), .PAR(1)) u_pe (
    .c(clk), .r(r), .din(din), .load(load_v[1]),
    .ready(ready_v[1]), .sout(sout_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  ser_tx #(.W(8), .CPB(1), .PAR(2)) u_po (
    .c(clk), .r(r), .din(din), .load(load_v[2]),
    .ready(ready_v[2]), .sout(sout_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  ser_tx #(.W(8), .CPB(4), .PAR(0)) u_c4 (
    .c(clk), .r(r), .din(din), .load(load_v[3]),
    .ready(ready_v[3]), .sout(sout_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Monitor: compares every queued expectation at its cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cy < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)",
               sb[0].tag, sb[0].cy, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cy == cyc) begin
      rec_t rc;
      rc = sb.pop_front();
      checks++;
      if (obs !== rc.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d sout/busy/ready/done got=%b expected=%b",
                 rc.tag, cyc, obs, rc.exp);
      end
    end
  end

  task automatic push_rec(input int cy, input logic [3:0] ex, input string tag);
    rec_t rc;
    rc.cy  = cy;
    rc.exp = ex;
    rc.tag = tag;
    sb.push_back(rc);
  endtask

  // fr holds the frame bits in transmit order (bit 0 = start bit).
  // Cycle a is the first cycle after the accepting edge.
  task automatic push_frame(input logic [11:0] fr, input int n, input int cpb,
                            input int a, input int lim, input string tag);
    for (int j = 0; j < lim; j++)
      push_rec(a + j, {fr[j / cpb], 1'b1, 1'b0, 1'b0}, tag);
    if (lim == n * cpb)
      push_rec(a + n * cpb, 4'b1011, {tag, "_done"});
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic [11:0] fr,
                      input int n, input int cpb, input string tag);
    int e;
    @(posedge clk); #1;
    sel  = k;
    din  = d;
    load = 1'b1;
    e    = cyc;
    push_frame(fr, n, cpb, e + 1, n * cpb, tag);
    push_rec(e + n * cpb + 2, 4'b1010, {tag, "_after"});
    @(posedge clk); #1;
    load = 1'b0;
    din  = 8'hC3;
    repeat (n * cpb + 1) @(posedge clk);
  endtask

  initial begin
    int e;
    int a;

    // Reset for two edges, then idle with load low.
    repeat (2) @(posedge clk);
    #1;
    r = 1'b0;
    e = cyc;
    for (int j = 0; j <= 5; j++) push_rec(e + j, 4'b1010, "reset_idle");
    repeat (6) @(posedge clk);

    // Single frames: A5 -> 0,1,0,1,0,0,1,0,1,1 (+ parity before stop).
    send(0, 8'hA5, 12'h34A, 10, 1, "a5_nopar");
    send(1, 8'hA5, 12'h54A, 11, 1, "a5_even");
    send(2, 8'hA5, 12'h74A, 11, 1, "a5_odd");
    send(3, 8'h01, 12'h202, 10, 4, "cpb4_01");

    // Back-to-back with load held: FF then 00, din changed mid-frame.
    @(posedge clk); #1;
    sel  = 0;
    din  = 8'hFF;
    load = 1'b1;
    e    = cyc;
    push_frame(12'h3FE, 10, 1, e + 1, 10, "b2b_ff");
    push_frame(12'h200, 10, 1, e + 12, 10, "b2b_00");
    push_rec(e + 23, 4'b1010, "b2b_after");
    repeat (4) @(posedge clk);
    #1 din = 8'h00;
    repeat (8) @(posedge clk);
    #1;
    load = 1'b0;
    din  = 8'h5A;
    repeat (11) @(posedge clk);

    // Reset during data bit 3 of din=00, then a clean frame.
    @(posedge clk); #1;
    sel  = 0;
    din  = 8'h00;
    load = 1'b1;
    e    = cyc;
    a    = e + 1;
    push_frame(12'h200, 10, 1, a, 5, "rstmid_pre");
    for (int j = 5; j <= 7; j++) push_rec(a + j, 4'b1010, "rstmid_abort");
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1 r = 1'b1;
    @(posedge clk);
    #1 r = 1'b0;
    repeat (2) @(posedge clk);
    send(0, 8'h3C, 12'h278, 10, 1, "post_rst_3c");

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
Parallel-to-serial frame transmitter. It is the driving end of the serial bit stream that our registered capture stages (d-input flops clocked on c, synchronous reset r) sample. It accepts a W-bit word on a valid/ready handshake and shifts it out on a single line. The frame is: start bit (0), W data bits LSB first, optional parity bit, stop bit (1). Each bit is held for CPB clocks. The line idles high.

Parameters:
W, 8, data word width (>=1)
CPB, 1, clocks per bit (>=1); bit-period counter width is clog2(CPB), minimum 1
PAR, 0, parity mode: 0 none, 1 even, 2 odd; any other value is treated as 0

Ports:
c  input  1  clock; all state updates on posedge c
r  input  1  reset, synchronous, active-high
din  input  W  word to transmit; sampled only on the accepting edge
load  input  1  request to transmit din
ready  output  1  high only in IDLE; a transfer happens on an edge where ready&load
sout  output  1  serial line, registered
busy  output  1  high from the edge after accept until return to IDLE
done  output  1  one-cycle pulse in the first IDLE cycle after a stop bit

Behaviour:
- Reset (r=1 at posedge) gives: state=IDLE, sout=1, busy=0, done=0, shift register=0, bit counter=0, period counter=0. ready=1 from the first cycle after reset. r overrides all other inputs.
- Reset mid-frame aborts the frame. The line returns to 1 in the cycle after the reset edge. No done pulse is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - sout=1, ready=1, busy=0.
  - On an edge with load=1: latch din into the shift register, compute the parity bit from din (even: XOR of bits; odd: inverted XOR), go to START, set sout=0 and busy=1, clear the period counter.
  - With load=0: stay in IDLE.
- START: sout=0 for CPB cycles, then DATA with sout=shreg[0].
- DATA:
  - Each bit is held CPB cycles. At the end of a bit period, shift right and increment the bit counter.
  - After bit W-1, go to PARITY (PAR!=0) or STOP (PAR=0).
- PARITY: sout=parity bit for CPB cycles, then STOP.
- STOP: sout=1 for CPB cycles, then IDLE. done=1 for exactly that first IDLE cycle.
- Frame timing: with accept at edge k, the frame occupies edges k..k+N*CPB, where N = W+2+(PAR!=0 ? 1 : 0). done and ready are both high in the cycle following edge k+N*CPB.
- load while busy is ignored and not queued. din changes during a frame have no effect.
- Back-to-back transfers: load held high re-accepts on the first IDLE edge. The minimum high gap between frames is therefore CPB+1 cycles (stop bit plus one IDLE cycle).
- The period counter wraps at CPB-1. With CPB=1 every bit lasts exactly one cycle and no counter stall occurs.
- No combinational path from load or din to sout. ready and busy decode directly from the state register.

Test Plan:
- Reset check: r=1 for 2 cycles, then r=0 -> sout=1, ready=1, busy=0, done=0; holds with load=0 for 5 cycles.
- Single frame, W=8, CPB=1, PAR=0: din=8'hA5, load for 1 cycle.
  - sout over the next 10 cycles: 0,1,0,1,0,0,1,0,1,1.
  - done=1 in cycle 11 only; busy high cycles 1-10.
- Parity, CPB=1, din=8'hA5:
  - PAR=1 -> bit after data is 0.
  - PAR=2 -> bit after data is 1.
  - Frame length is 11 cycles in both cases.
- Bit stretching, CPB=4, PAR=0: din=8'h01 -> start low 4 cycles, then high 4 cycles, then 28 low, then stop high 4 cycles; done after cycle 40.
- Back-to-back with ignored load, CPB=1, PAR=0:
  - load held high with din=8'hFF, then din=8'h00 for the second frame.
  - Second frame starts exactly 1 IDLE cycle after the first frame's stop bit.
  - din changes mid-frame do not alter the bits in flight.
- Reset mid-frame: assert r during DATA bit 3 of din=8'h00 -> next cycle sout=1, ready=1, busy=0, no done pulse; the next load transmits a full correct frame.
